uart_term_ctrl: RTL and testbench
=================================

Name: uart_term_ctrl

Overview:
Terminal controller sitting between the 16x-oversampled UART receiver and the text-mode character buffer of the VGA display.
- Captures each completed received byte into a small FIFO.
- Interprets printable, carriage-return and backspace codes.
- Writes characters into the character buffer at a managed cursor position.
- Echoes every accepted byte back through the UART transmitter, sequencing both resources one byte at a time.

Parameters:
FIFO_DEPTH, 8, byte FIFO entries (power of two, >=2)
COLS, 80, text columns (640 px / 8 px glyph)
ROWS, 30, text rows (480 px / 16 px glyph)
ADDR_W, 12, character-buffer address width (COLS*ROWS must fit)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous, active-low reset
rx_received  input  1  receiver done level; rises when a byte completes, falls at next start bit
rx_data  input  8  received byte; valid while rx_received high
tx_busy  input  1  transmitter busy; high from the cycle after tx_start until the frame ends
tx_start  output  1  one-cycle echo request
tx_data  output  8  echo byte; valid with tx_start
wr_en  output  1  one-cycle character-buffer write strobe
wr_addr  output  ADDR_W  cursor_y*COLS+cursor_x
wr_char  output  8  character code to store
cursor_x  output  7  current column
cursor_y  output  5  current row
overflow  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low at posedge):
  - tx_start, wr_en, overflow = 0; tx_data, wr_char, wr_addr = 0.
  - cursor = (0,0); FIFO emptied; FSM = IDLE.
  - Edge-detect register rx_prev = 1, so a stale high rx_received after reset is not captured.
- Capture: push rx_data when rx_received=1 && rx_prev=0; rx_prev <= rx_received every cycle.
  - Full FIFO: byte dropped, overflow <= 1 until reset.
  - Push and pop in the same cycle is legal; occupancy unchanged; a full FIFO popping that cycle accepts the push.
- FSM (one byte in flight):
  - IDLE: if FIFO non-empty, pop the head into cur, go to EXEC. Otherwise stay.
  - EXEC: classify cur:
    - 0x20-0x7E: wr_en=1, wr_char=cur, wr_addr=current cursor. Advance: x+1; if x==COLS-1 then x=0, y=(y==ROWS-1)?0:y+1.
    - 0x0D: no write; x=0, y=(y==ROWS-1)?0:y+1.
    - 0x08 or 0x7F: if x>0, wr_en=1, wr_char=0x20 at (x-1,y), x<=x-1. If x==0, no write, no cursor change, still echoed.
    - Any other code: discarded, no write, no echo, go to IDLE.
    - Accepted bytes go to ECHO.
  - ECHO: wait while tx_busy=1. When tx_busy=0, tx_start=1 for exactly one cycle with tx_data=cur, go to GUARD.
  - GUARD: one cycle, lets tx_busy rise; go to IDLE.
- Latency:
  - Capture edge at cycle N: pop at N+1, wr_en at N+2.
  - tx_start no earlier than N+3, later while tx_busy is high.
- Cursor outputs update on the same edge that retires EXEC. wr_addr during wr_en reflects the pre-update target.
- Row wrap goes to row 0 with no scrolling; old text is overwritten.
- Arithmetic: wr_addr computed unsigned at ADDR_W bits; no overflow for the defaults (max 2399).
- Reset mid-operation: any pending echo or write is abandoned and no strobe is emitted on the reset cycle.

Decomposition:
- Package uart_term_pkg:
  - ASCII constants: CR=0x0D, BS=0x08, DEL=0x7F, SPACE=0x20, PRINT_LO=0x20, PRINT_HI=0x7E.
  - Default COLS/ROWS.
  - FSM state enum {IDLE, EXEC, ECHO, GUARD}.
- One sub-module: byte_fifo, a synchronous FIFO.
  - Parameters: DEPTH, width 8.
  - Ports: push, pop, din, dout (head visible combinationally), full, empty.
  - Same clk/rst_n convention.

Test Plan:
- Reset then send 0x41 ('A') -> one wr_en with addr 0, char 0x41; cursor (1,0); one tx_start with 0x41; overflow 0.
- From cursor (79,0) send 'Z' -> write at addr 79; cursor (0,1). From (79,29) send 'Z' -> write at addr 2399; cursor (0,0).
- Send 'H','I',0x08 -> writes at 0 and 1, then space at addr 1; cursor (1,0). Send 0x08 at (0,5) -> no wr_en, cursor unchanged, echo 0x08.
- Send 0x0D at (12,3) -> no wr_en, cursor (0,4), echo 0x0D. Send 0x07 -> no write, no echo, cursor unchanged.
- Hold tx_busy=1 and send 10 bytes back-to-back -> first byte processed, remaining 8 fill the FIFO, 10th dropped, overflow=1. Release tx_busy -> 9 echoes, in order.
- Assert rst_n=0 while in ECHO with rx_received held high -> outputs zero, cursor (0,0). After release, no spurious capture until rx_received falls and rises again.

Source files
------------

// File: rtl/uart_term_pkg.sv
// Shared constants, FSM state type and byte classifier for the
// UART terminal controller.
package uart_term_pkg;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] DEL      = 8'h7F;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ECHO,
    GUARD
  } state_t;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO, head visible combinationally on dout.
// Ports: push/din write, pop read, full/empty status.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];

  // A full FIFO that pops this cycle frees a slot for the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_term_ctrl.sv
// UART-to-text-buffer terminal: captures rx bytes, writes glyphs
// at the cursor, echoes accepted bytes; all outputs registered.
module uart_term_ctrl
  import uart_term_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_received,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_char,
  output logic [6:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              overflow
);

  state_t state, state_n;

  logic              rx_prev;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [7:0]        head;
  logic [7:0]        cur, cur_n;
  logic [6:0]        x_n;
  logic [4:0]        y_n;
  logic [4:0]        row_next;
  logic              last_col;
  logic              tx_start_n;
  logic [7:0]        tx_data_n;
  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_char_n;

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [6:0] x,
    input logic [4:0] y
  );
    return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
  endfunction

  assign push     = rx_received && !rx_prev;
  assign last_col = cursor_x == 7'(COLS-1);
  assign row_next = (cursor_y == 5'(ROWS-1)) ?
                    5'd0 : cursor_y + 5'd1;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    cur_n      = cur;
    x_n        = cursor_x;
    y_n        = cursor_y;
    tx_start_n = 1'b0;
    tx_data_n  = tx_data;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_char_n  = wr_char;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_n   = head;
          state_n = EXEC;
        end
      end
      EXEC: begin
        state_n = ECHO;
        unique case (1'b1)
          is_print(cur): begin
            wr_en_n   = 1'b1;
            wr_char_n = cur;
            wr_addr_n = addr_of(cursor_x, cursor_y);
            if (last_col) begin
              x_n = 7'd0;
              y_n = row_next;
            end else begin
              x_n = cursor_x + 7'd1;
            end
          end
          (cur == CR): begin
            x_n = 7'd0;
            y_n = row_next;
          end
          (cur == BS || cur == DEL): begin
            // At column 0 the byte is still echoed.
            if (cursor_x != 7'd0) begin
              wr_en_n   = 1'b1;
              wr_char_n = SPACE;
              wr_addr_n = addr_of(cursor_x - 7'd1,
                                  cursor_y);
              x_n       = cursor_x - 7'd1;
            end
          end
          default: state_n = IDLE;
        endcase
      end
      ECHO: begin
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          tx_data_n  = cur;
          state_n    = GUARD;
        end
      end
      // One dead cycle so tx_busy is seen high next time.
      GUARD: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rx_prev  <= 1'b1;
      cur      <= 8'd0;
      cursor_x <= 7'd0;
      cursor_y <= 5'd0;
      tx_start <= 1'b0;
      tx_data  <= 8'd0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_char  <= 8'd0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      rx_prev  <= rx_received;
      cur      <= cur_n;
      cursor_x <= x_n;
      cursor_y <= y_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
      wr_en    <= wr_en_n;
      wr_addr  <= wr_addr_n;
      wr_char  <= wr_char_n;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_term_ctrl.sv
// Scoreboard bench for uart_term_ctrl: a linear-position screen
// model predicts writes and echoes; a monitor checks them.
module tb_uart_term_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int TOTAL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_received = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_char;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        overflow;

  logic hold = 1'b0;
  logic frame = 1'b0;
  assign tx_busy = hold | frame;

  uart_term_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_received (rx_received),
    .rx_data     (rx_data),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int echo_seen = 0;
  int pos = 0;
  int exp_ovf = 0;
  logic [19:0] wq[$];
  logic [7:0]  eq[$];

  // Transmitter: busy from the cycle after tx_start for a random frame.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_start && rst_n) begin
        @(posedge clk);
        #1 frame = 1'b1;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1 frame = 1'b0;
      end
    end
  end

  // Monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        compared++;
        if (wq.size() == 0) begin
          mismatched++;
          $display("FAIL wr_unexpected: addr %0d char %h, none expected",
                   wr_addr, wr_char);
        end else begin
          logic [19:0] e;
          e = wq.pop_front();
          if ({wr_addr, wr_char} !== e) begin
            mismatched++;
            $display("FAIL wr: got addr %0d char %h, expected addr %0d char %h",
                     wr_addr, wr_char, e[19:8], e[7:0]);
          end
        end
      end
      if (tx_start) begin
        echo_seen++;
        compared++;
        if (eq.size() == 0) begin
          mismatched++;
          $display("FAIL echo_unexpected: byte %h, none expected", tx_data);
        end else begin
          logic [7:0] e;
          e = eq.pop_front();
          if (tx_data !== e) begin
            mismatched++;
            $display("FAIL echo: got %h expected %h", tx_data, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Screen model over a linear position 0..TOTAL-1.
  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      wq.push_back({12'(pos), b});
      eq.push_back(b);
      pos = (pos + 1) % TOTAL;
    end else if (b == 8'h0D) begin
      eq.push_back(b);
      pos = ((pos / COLS + 1) % ROWS) * COLS;
    end else if (b == 8'h08 || b == 8'h7F) begin
      eq.push_back(b);
      if (pos % COLS != 0) begin
        wq.push_back({12'(pos - 1), 8'h20});
        pos = pos - 1;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_received = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_m(input logic [7:0] b, input int gap);
    model(b);
    send(b, gap);
  endtask

  task automatic drain(input string name);
    repeat (300) @(negedge clk);
    chk({name, "_writes_left"}, wq.size(), 0);
    chk({name, "_echoes_left"}, eq.size(), 0);
    wq.delete();
    eq.delete();
  endtask

  task automatic chk_cursor(input string name);
    chk({name, "_x"}, int'(cursor_x), pos % COLS);
    chk({name, "_y"}, int'(cursor_y), pos / COLS);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_tx_start"}, int'(tx_start), 0);
    chk({name, "_wr_en"}, int'(wr_en), 0);
    chk({name, "_wr_addr"}, int'(wr_addr), 0);
    chk({name, "_wr_char"}, int'(wr_char), 0);
    chk({name, "_tx_data"}, int'(tx_data), 0);
    chk({name, "_overflow"}, int'(overflow), 0);
    chk({name, "_cx"}, int'(cursor_x), 0);
    chk({name, "_cy"}, int'(cursor_y), 0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 8'($urandom_range(32, 126));
    if (r == 6) return 8'h0D;
    if (r == 7) return 8'h08;
    if (r == 8) return 8'h7F;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int start;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    send_m(8'h41, 2);
    drain("char_A");
    chk_cursor("after_A");
    chk("ovf_A", int'(overflow), 0);

    for (int i = 0; i < 78; i++) send_m(8'($urandom_range(33, 126)), 20);
    drain("fill_row0");
    chk_cursor("at_79_0");
    send_m(8'h5A, 2);
    drain("z_end_row0");
    chk_cursor("wrap_row1");

    for (int i = 0; i < 28; i++) send_m(8'h0D, 20);
    for (int i = 0; i < 79; i++) send_m(8'($urandom_range(33, 126)), 20);
    drain("fill_row29");
    chk_cursor("at_79_29");
    send_m(8'h5A, 2);
    drain("z_last_cell");
    chk_cursor("wrap_origin");

    send_m(8'h48, 20);
    send_m(8'h49, 20);
    send_m(8'h08, 20);
    drain("hi_bs");
    chk_cursor("after_hi_bs");

    for (int i = 0; i < 5; i++) send_m(8'h0D, 20);
    drain("to_0_5");
    send_m(8'h08, 20);
    drain("bs_col0");
    chk_cursor("bs_col0");

    for (int i = 0; i < 28; i++) send_m(8'h0D, 20);
    for (int i = 0; i < 12; i++) send_m(8'($urandom_range(33, 126)), 20);
    drain("to_12_3");
    chk_cursor("at_12_3");
    send_m(8'h0D, 20);
    drain("cr");
    chk_cursor("after_cr");
    start = echo_seen;
    send_m(8'h07, 20);
    drain("bell");
    chk_cursor("after_bell");
    chk("bell_no_echo", echo_seen - start, 0);

    for (int b = 0; b < 10; b++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) send_m(rand_byte(), $urandom_range(0, 5));
      drain("random_burst");
      chk_cursor("random_burst");
    end
    chk("ovf_before_burst", int'(overflow), 0);

    hold = 1'b1;
    start = echo_seen;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) model(8'h61 + 8'(i));
      send(8'h61 + 8'(i), 0);
    end
    repeat (20) @(negedge clk);
    chk("held_no_echo", echo_seen - start, 0);
    chk("ovf_after_burst", int'(overflow), 1);
    hold = 1'b0;
    drain("burst_release");
    chk("burst_echoes", echo_seen - start, 9);
    chk_cursor("after_burst");
    chk("ovf_sticky", int'(overflow), 1);

    hold = 1'b1;
    @(negedge clk);
    rx_data = 8'h51;
    rx_received = 1'b1;
    model(8'h51);
    repeat (8) @(negedge clk);
    chk("pending_echo", eq.size(), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    eq.delete();
    wq.delete();
    pos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    start = echo_seen;
    repeat (30) @(negedge clk);
    chk("stale_no_echo", echo_seen - start, 0);
    chk_cursor("stale_no_capture");
    rx_received = 1'b0;
    send_m(8'h52, 2);
    drain("post_reset");
    chk_cursor("post_reset");
    chk("ovf_cleared", int'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
